wb_dest_pipe: RTL
=================

// Module: wb_dest_pipe
// PURPOSE
//  Parametrised write-back destination unit for the multicycle MIPS datapath.
//  - Selects the destination register (rt, rd, $ra or $sp) when an instruction is decoded.
//  - Carries that destination, with a valid bit, through DEPTH stages toward the register file.
//  - Presents the retiring destination to the register bank.
//  - Exports a busy scoreboard and source-hazard flags, which control uses to stall.
// PARAMETERS
//  ADDR_W   5   register address width (register file holds 2**ADDR_W registers)
//  IMM_W    16  width of the immediate/instruction field input
//  RD_LSB   11  LSB of the rd field inside imm_in (rd = imm_in[RD_LSB+ADDR_W-1:RD_LSB])
//  DEPTH    3   number of pipeline stages (legal range 1..8)
//  RA_ADDR  31  register number used by selector=2'b10
//  SP_ADDR  29  register number used by selector=2'b11
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             synchronous, active-high reset
//  selector   in   2             00=rt_in, 01=rd field of imm_in, 10=RA_ADDR, 11=SP_ADDR
//  rt_in      in   ADDR_W        rt field
//  imm_in     in   IMM_W         instruction low half (holds the rd field)
//  wr_en_in   in   1             the instruction writes a register
//  load       in   1             capture a new destination into stage 0
//  advance    in   1             shift every stage forward by one
//  flush      in   1             invalidate all stages
//  ready      out  1             combinational: load will be accepted this cycle
//  dest_out   out  ADDR_W        address held in the last stage (registered)
//  dest_valid out  1             last stage holds a live write (registered)
//  busy_mask  out  2**ADDR_W     bit r is 1 if any valid stage targets register r
//  src_a      in   ADDR_W        source operand A to check
//  src_b      in   ADDR_W        source operand B to check
//  hazard_a   out  1             busy_mask[src_a], combinational
//  hazard_b   out  1             busy_mask[src_b], combinational
// BEHAVIOUR
//  - Each stage i holds {v[i], a[i]}. Stage 0 is the entry; stage DEPTH-1 drives dest_out and dest_valid.
//  - Reset: all v=0 and all a=0, so dest_out=0, dest_valid=0, busy_mask=0.
//    Hazard outputs are 0 at reset. ready is 1 at reset.
//  - Entry value: sel_addr is the mux of selector as listed above.
//    Stage 0 captures v = wr_en_in && (sel_addr != 0); register $0 is never written or marked busy.
//  - ready = !v[0] || advance.
//  - Priority per clock edge: reset > flush > advance/load.
//  - flush=1: every v cleared and every a cleared. Any load in the same cycle is discarded.
//  - advance=1:
//      stage[i] <= stage[i-1] for i>=1.
//      The old last-stage entry retires.
//      Stage 0 takes the new entry if load=1, otherwise v[0] <= 0.
//  - advance=0, load=1, v[0]=0: stage 0 captures the new entry. Other stages hold.
//  - advance=0, load=1, v[0]=1: the load is ignored and state is unchanged. ready=0 flags this case.
//  - advance=0, load=0: all stages hold.
//  - Latency: a loaded entry appears on dest_out after DEPTH advance edges, counting the load edge if advance was high on it.
//    With DEPTH=1 and advance=0, it appears on the edge after load.
//  - busy_mask: OR of the one-hot decodes of every valid stage, including stage 0. It is computed from registered state, so it is glitch-free.
//    Duplicate targets in several stages keep the bit set until the last one retires.
//  - A register is counted busy through the cycle in which dest_valid presents it.
//    Control stalls readers until that entry has retired.
//  - selector is used only when load is accepted. rt_in and imm_in are don't-care otherwise.
//  - Invalid stages always hold a=0, so a bubble shows dest_out=0.
// TESTING
//  1. Reset held 2 cycles -> dest_valid=0, dest_out=0, busy_mask=0, ready=1.
//  2. sel=01, imm_in=16'h4020 (rd=8), wr_en=1, load+advance held 3 cycles (DEPTH=3)
//     -> dest_out=8 and dest_valid=1 on the 3rd edge; busy_mask[8]=1 from the 1st edge.
//  3. sel=10, load, then src_a=31 -> hazard_a=1 until $ra retires; after one more advance, busy_mask[31]=0.
//  4. sel=00, rt_in=0, wr_en=1, load -> v[0]=0, busy_mask=0, nothing ever reaches dest_valid.
//  5. load with advance=0, then a second load with advance=0 -> ready=0 and stage 0 still holds the first address.
//  6. Pipe full with 9,10,11, then flush asserted together with load -> all v=0 next cycle, busy_mask=0, new entry dropped.

Source files
------------

// File: rtl/wb_dest_pipe.sv
// Write-back destination pipe for the multicycle MIPS datapath.
// Picks the destination register at decode time and carries {valid, addr}
// through DEPTH stages toward the register file. It also exports a busy
// scoreboard and source-hazard flags so control can stall readers.

// One pipeline slot: holds {v, a} and publishes a one-hot decode of its
// target when valid. An invalid slot always holds a=0.
module wb_dest_stage #(
    parameter int ADDR_W = 5,
    parameter int NREG   = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              en,
    input  logic              d_v,
    input  logic [ADDR_W-1:0] d_a,
    output logic              q_v,
    output logic [ADDR_W-1:0] q_a,
    output logic [NREG-1:0]   dec
);

    // Capture on enable. The address is forced to 0 whenever the entry is
    // not valid, so bubbles always present a=0.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q_v <= 1'b0;
            q_a <= '0;
        end else if (en) begin
            q_v <= d_v;
            q_a <= d_v ? d_a : '0;
        end
    end

    // One-hot busy contribution of this slot. It is decoded from registered
    // state, so it does not glitch.
    always_comb begin
        dec      = '0;
        dec[q_a] = q_v;
    end

endmodule

module wb_dest_pipe #(
    parameter int               ADDR_W  = 5,
    parameter int               IMM_W   = 16,
    parameter int               RD_LSB  = 11,
    parameter int               DEPTH   = 3,
    parameter logic [ADDR_W-1:0] RA_ADDR = 31,
    parameter logic [ADDR_W-1:0] SP_ADDR = 29
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            selector,
    input  logic [ADDR_W-1:0]     rt_in,
    input  logic [IMM_W-1:0]      imm_in,
    input  logic                  wr_en_in,
    input  logic                  load,
    input  logic                  advance,
    input  logic                  flush,
    output logic                  ready,
    output logic [ADDR_W-1:0]     dest_out,
    output logic                  dest_valid,
    output logic [(1<<ADDR_W)-1:0] busy_mask,
    input  logic [ADDR_W-1:0]     src_a,
    input  logic [ADDR_W-1:0]     src_b,
    output logic                  hazard_a,
    output logic                  hazard_b
);

    localparam int NREG = 1 << ADDR_W;

    logic [ADDR_W-1:0]             sel_addr;
    logic                          new_v;
    logic [DEPTH-1:0]              vld_pipe;
    logic [DEPTH-1:0][ADDR_W-1:0]  adr_pipe;
    logic [DEPTH-1:0]              stg_en;
    logic [DEPTH-1:0]              stg_dv;
    logic [DEPTH-1:0][ADDR_W-1:0]  stg_da;
    logic [DEPTH-1:0][NREG-1:0]    stg_dec;
    logic                          unused_imm;

    // Only the rd field of imm_in is consumed. The remaining bits are
    // folded here so their non-use is deliberate.
    assign unused_imm = ^imm_in;

    // Destination select. Only sampled when stage 0 actually takes the load.
    always_comb begin
        sel_addr = rt_in;
        case (selector)
            2'b00:   sel_addr = rt_in;
            2'b01:   sel_addr = imm_in[RD_LSB +: ADDR_W];
            2'b10:   sel_addr = RA_ADDR;
            default: sel_addr = SP_ADDR;
        endcase
    end

    // $0 is hard-wired, so a write to it never becomes a live entry.
    assign new_v = wr_en_in && (sel_addr != '0);

    // Stage 0 is free when it is empty, or when it is emptying this edge.
    assign ready = !vld_pipe[0] || advance;

    // Stage inputs and enables. When stage 0 is advanced without a load, it
    // takes a bubble. A load into an occupied, non-advancing stage 0 is dropped.
    always_comb begin
        stg_en    = '0;
        stg_dv    = '0;
        stg_da    = '0;
        stg_en[0] = advance || (load && !vld_pipe[0]);
        stg_dv[0] = load && new_v;
        stg_da[0] = sel_addr;
        for (int i = 1; i < DEPTH; i++) begin
            stg_en[i] = advance;
            stg_dv[i] = vld_pipe[i-1];
            stg_da[i] = adr_pipe[i-1];
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            wb_dest_stage #(
                .ADDR_W (ADDR_W),
                .NREG   (NREG)
            ) u_stage (
                .clk   (clk),
                .reset (reset),
                .flush (flush),
                .en    (stg_en[g]),
                .d_v   (stg_dv[g]),
                .d_a   (stg_da[g]),
                .q_v   (vld_pipe[g]),
                .q_a   (adr_pipe[g]),
                .dec   (stg_dec[g])
            );
        end
    endgenerate

    // The retiring slot goes to the register bank.
    assign dest_out   = adr_pipe[DEPTH-1];
    assign dest_valid = vld_pipe[DEPTH-1];

    // Scoreboard: OR of every slot's decode. Duplicate targets keep the bit
    // set until the last copy retires.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            busy_mask = busy_mask | stg_dec[i];
    end

    assign hazard_a = busy_mask[src_a];
    assign hazard_b = busy_mask[src_b];

endmodule
